nrbd_nrsc_param: RTL and testbench

- Parametrised non-restoring binary divider / square-root core for normalised mantissas. It is the generalised successor of the fixed-format FP64/FP32/FP16 iterative divsqrt datapath.
- The mantissa width is set by parameter. UNROLL result bits are retired per cycle.
- Adds a Ready/Start handshake, Kill abort, a sticky (inexact) output, a divide-by-zero flag and odd-exponent radicand pre-shift.
- Sits between the divsqrt preprocess (unpack/exponent) and the rounding/normalisation stage.

---
 rtl/nrbd_nrsc_param.sv | 169 ++++++++++++++++
 tb/tb_nrbd_nrsc_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/nrbd_nrsc_param.sv
// Non-restoring divider / square-root core for normalised mantissas, UNROLL result bits per cycle.
// Latency: Start accepted at edge 0 -> Done_SO pulses in cycle ITERS+1 (cycle 2 for a zero divisor).
// Backpressure: Start_SI is taken only while Ready_SO=1; requests at other times are dropped, never queued.
//
// Ports:
//   Clk_CI, Rst_RBI          clock, asynchronous active-low reset
//   Start_SI, Sqrt_SI        request, mode (0=divide, 1=sqrt), sampled at accept
//   Odd_exp_SI               sqrt only: radicand is doubled before the root is taken
//   Kill_SI                  abort the running operation (no Done); beats Start in IDLE
//   Mant_a_DI, Mant_b_DI     numerator/radicand and denominator, hidden bit at MSB
//   Ready_SO, Done_SO        can-accept flag, one-cycle result-valid pulse
//   Mant_z_DO                result, 1 integer bit + WIDTH+2 fraction bits
//   Sticky_SO, Div_zero_SO   inexact flag, zero-divisor flag; held with Mant_z_DO
module nrbd_nrsc_param #(
    parameter int WIDTH  = 24,
    parameter int UNROLL = 1
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic             Start_SI,
    input  logic             Sqrt_SI,
    input  logic             Odd_exp_SI,
    input  logic             Kill_SI,
    input  logic [WIDTH-1:0] Mant_a_DI,
    input  logic [WIDTH-1:0] Mant_b_DI,
    output logic             Ready_SO,
    output logic             Done_SO,
    output logic [WIDTH+2:0] Mant_z_DO,
    output logic             Sticky_SO,
    output logic             Div_zero_SO
);

    localparam int RES_W      = WIDTH + 3;
    localparam int REM_W      = RES_W + 3;
    localparam int RAD_W      = 2 * RES_W;
    localparam int ITERS      = (RES_W + UNROLL - 1) / UNROLL;
    // Steps that are real in the last cycle; the rest of that cycle is masked.
    localparam int LAST_STEPS = RES_W - (ITERS - 1) * UNROLL;
    localparam int CNT_W      = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sqrt_q;
    logic               dz_q;
    logic [REM_W-1:0]   rem_q;      // signed partial remainder
    logic [RES_W-1:0]   quo_q;      // quotient / developing root
    logic [RAD_W-1:0]   rad_q;      // radicand bits not yet consumed, two per sqrt step
    logic [REM_W-1:0]   dvs_q;      // divisor pre-doubled, see note on the divide step

    logic [REM_W-1:0]   rem_nxt;
    logic [RES_W-1:0]   quo_nxt;
    logic [RAD_W-1:0]   rad_nxt;
    logic [REM_W-1:0]   sh;
    logic [REM_W-1:0]   trial;
    logic               neg;
    logic [REM_W-1:0]   rem_fix;

    // UNROLL chained steps. Every step shifts the remainder first, then adds
    // or subtracts depending on the sign it had before the shift. The divide
    // remainder is kept at twice its natural scale (start = A, term = 2B) so
    // that divide and sqrt share the shift-then-add shape. The recorded bit is
    // the sign of the new remainder, which is already the restoring digit, so
    // only the remainder needs fixing up at the end.
    always_comb begin
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        rad_nxt = rad_q;
        sh      = '0;
        trial   = '0;
        neg     = 1'b0;
        for (int u = 0; u < UNROLL; u++) begin
            if (!(cnt_q == '0 && u >= LAST_STEPS)) begin
                neg = rem_nxt[REM_W-1];
                if (sqrt_q) begin
                    sh      = {rem_nxt[REM_W-3:0], rad_nxt[RAD_W-1 -: 2]};
                    trial   = {1'b0, quo_nxt, neg, 1'b1};   // 4Q+1 or 4Q+3
                    rad_nxt = {rad_nxt[RAD_W-3:0], 2'b00};
                end else begin
                    sh      = {rem_nxt[REM_W-2:0], 1'b0};
                    trial   = dvs_q;
                end
                rem_nxt = neg ? (sh + trial) : (sh - trial);
                quo_nxt = {quo_nxt[RES_W-2:0], ~rem_nxt[REM_W-1]};
            end
        end
    end

    // Final correction: a negative remainder gets the last term back so the
    // sticky test sees the true remainder (divide: +2B, sqrt: +2Q+1).
    always_comb begin
        rem_fix = rem_q;
        if (rem_q[REM_W-1]) begin
            rem_fix = rem_q + (sqrt_q ? {2'b00, quo_q, 1'b1} : dvs_q);
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sqrt_q      <= 1'b0;
            dz_q        <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            rad_q       <= '0;
            dvs_q       <= '0;
            Ready_SO    <= 1'b1;
            Done_SO     <= 1'b0;
            Mant_z_DO   <= '0;
            Sticky_SO   <= 1'b0;
            Div_zero_SO <= 1'b0;
        end else begin
            Done_SO <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start_SI && Ready_SO && !Kill_SI) begin
                        state_q  <= ITER;
                        cnt_q    <= CNT_W'(ITERS - 1);
                        Ready_SO <= 1'b0;
                        sqrt_q   <= Sqrt_SI;
                        dz_q     <= !Sqrt_SI && (Mant_b_DI == '0);
                        rem_q    <= Sqrt_SI ? '0 : REM_W'(Mant_a_DI);
                        quo_q    <= '0;
                        rad_q    <= {(Odd_exp_SI ? {Mant_a_DI, 1'b0} : {1'b0, Mant_a_DI}),
                                     {(WIDTH + 5){1'b0}}};
                        dvs_q    <= {{(REM_W - WIDTH - 1){1'b0}}, Mant_b_DI, 1'b0};
                    end else begin
                        // Also re-opens the core the cycle after a Done.
                        Ready_SO <= 1'b1;
                    end
                end
                ITER: begin
                    if (Kill_SI) begin
                        state_q  <= IDLE;
                        Ready_SO <= 1'b1;
                    end else if (dz_q) begin
                        state_q <= FIN;
                    end else begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        rad_q <= rad_nxt;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    if (Kill_SI) begin
                        Ready_SO <= 1'b1;
                    end else begin
                        Done_SO     <= 1'b1;
                        Mant_z_DO   <= dz_q ? '1 : quo_q;
                        Sticky_SO   <= !dz_q && (rem_fix != '0);
                        Div_zero_SO <= dz_q;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    Ready_SO <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrbd_nrsc_param.sv
module tb_nrbd_nrsc_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, sqrt, odd, kill;
    logic [23:0] a, b;

    logic        rdy1, rdy3, rdy4, done1, done3, done4;
    logic [26:0] z1, z3, z4;
    logic        st1, st3, st4, dz1, dz3, dz4;

    nrbd_nrsc_param #(.WIDTH(24), .UNROLL(1)) u1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Sqrt_SI(sqrt),
        .Odd_exp_SI(odd), .Kill_SI(kill), .Mant_a_DI(a), .Mant_b_DI(b),
        .Ready_SO(rdy1), .Done_SO(done1), .Mant_z_DO(z1), .Sticky_SO(st1),
        .Div_zero_SO(dz1));

    nrbd_nrsc_param #(.WIDTH(24), .UNROLL(3)) u3 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Sqrt_SI(sqrt),
        .Odd_exp_SI(odd), .Kill_SI(kill), .Mant_a_DI(a), .Mant_b_DI(b),
        .Ready_SO(rdy3), .Done_SO(done3), .Mant_z_DO(z3), .Sticky_SO(st3),
        .Div_zero_SO(dz3));

    nrbd_nrsc_param #(.WIDTH(24), .UNROLL(4)) u4 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .Start_SI(start), .Sqrt_SI(sqrt),
        .Odd_exp_SI(odd), .Kill_SI(kill), .Mant_a_DI(a), .Mant_b_DI(b),
        .Ready_SO(rdy4), .Done_SO(done4), .Mant_z_DO(z4), .Sticky_SO(st4),
        .Div_zero_SO(dz4));

    int total = 0;
    int bad   = 0;
    int dc1, dc3, dc4, rc1, dn1, dn3, dn4;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request at edge 0, then watch cycles 0..35 (sampled on the
    // falling edge). kc: cycle during which Kill is held (-1 = never).
    // gl: throw a stray Start with different operands at cycle 3.
    task launch(input logic [23:0] ta, input logic [23:0] tb_, input logic ts,
                input logic to, input logic tk0, input int kc, input logic gl);
        @(negedge clk);
        a = ta; b = tb_; sqrt = ts; odd = to; start = 1'b1; kill = tk0;
        dc1 = -1; dc3 = -1; dc4 = -1; rc1 = -1;
        dn1 = 0;  dn3 = 0;  dn4 = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (done1) begin dn1++; if (dc1 < 0) dc1 = c; end
            if (done3) begin dn3++; if (dc3 < 0) dc3 = c; end
            if (done4) begin dn4++; if (dc4 < 0) dc4 = c; end
            if (rdy1 && rc1 < 0) rc1 = c;
            kill = (c == kc);
            if (gl && c == 3) begin
                start = 1'b1; a = 24'hFFFFFF; b = 24'h000000; sqrt = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sqrt = 1'b0; odd = 1'b0; kill = 1'b0;
        a = 24'h800000; b = 24'h800000;
        repeat (3) @(negedge clk);
        chk("rst_ready",  64'(rdy1), 64'h1);
        chk("rst_done",   64'(done1), 64'h0);
        chk("rst_z",      64'(z1), 64'h0);
        chk("rst_sticky", 64'(st1), 64'h0);
        chk("rst_dz",     64'(dz1), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // identity divide on all three unroll factors
        launch(24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        chk("id_done_u1",  64'(dc1), 64'd28);
        chk("id_ready_u1", 64'(rc1), 64'd29);
        chk("id_done_u3",  64'(dc3), 64'd10);
        chk("id_done_u4",  64'(dc4), 64'd8);
        chk("id_z_u1",     64'(z1), 64'h4000000);
        chk("id_z_u3",     64'(z3), 64'h4000000);
        chk("id_z_u4",     64'(z4), 64'h4000000);
        chk("id_sticky",   64'(st1), 64'h0);
        chk("id_npulse",   64'(dn1), 64'd1);

        // 1/1.5 with a stray Start during iteration
        launch(24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        chk("d23_z_u1",    64'(z1), 64'h2AAAAAA);
        chk("d23_sticky",  64'(st1), 64'h1);
        chk("d23_z_u4",    64'(z4), 64'h2AAAAAA);
        chk("d23_done",    64'(dc1), 64'd28);
        chk("d23_npulse",  64'(dn1), 64'd1);

        // 1.5/1
        launch(24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        chk("d32_z",       64'(z1), 64'h6000000);
        chk("d32_sticky",  64'(st1), 64'h0);

        // sqrt, even and odd exponent
        launch(24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        chk("sq1_z",       64'(z1), 64'h4000000);
        chk("sq1_sticky",  64'(st1), 64'h0);
        chk("sq1_dz",      64'(dz1), 64'h0);
        launch(24'h800000, 24'h123456, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        chk("sq2_z_u1",    64'(z1), 64'h5A82799);
        chk("sq2_sticky",  64'(st1), 64'h1);
        chk("sq2_z_u3",    64'(z3), 64'h5A82799);
        chk("sq2_z_u4",    64'(z4), 64'h5A82799);

        // divide by zero
        launch(24'h800000, 24'h000000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        chk("dz_done_u1",  64'(dc1), 64'd2);
        chk("dz_done_u4",  64'(dc4), 64'd2);
        chk("dz_z",        64'(z1), 64'h7FFFFFF);
        chk("dz_flag",     64'(dz1), 64'h1);
        chk("dz_sticky",   64'(st1), 64'h0);

        // a following legal op clears the flag
        launch(24'hC00000, 24'h800000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        chk("dzclr_flag",  64'(dz1), 64'h0);
        chk("dzclr_z",     64'(z1), 64'h6000000);

        // Kill held during cycle 5
        launch(24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        chk("kill_npulse", 64'(dn1 + dn3 + dn4), 64'd0);
        chk("kill_ready",  64'(rc1), 64'd6);
        chk("kill_z",      64'(z1), 64'h6000000);
        chk("kill_sticky", 64'(st1), 64'h0);

        // Start and Kill together in IDLE
        launch(24'h800000, 24'hC00000, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        chk("sk_npulse",   64'(dn1 + dn3 + dn4), 64'd0);
        chk("sk_ready",    64'(rc1), 64'd0);
        chk("sk_z",        64'(z1), 64'h6000000);

        // reset in the middle of an operation
        @(negedge clk);
        a = 24'h800000; b = 24'hC00000; sqrt = 1'b0; odd = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_z",      64'(z1), 64'h0);
        chk("mrst_ready",  64'(rdy1), 64'h1);
        chk("mrst_done",   64'(done1), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn1 = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (done1 || done3 || done4) dn1++;
        end
        chk("mrst_npulse", 64'(dn1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
